// File: rtl/attn_value_matmul.sv
// attn_value_matmul: sequential O = A*V for one attention head, one output row per N cycles
module attn_value_matmul #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int N          = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N*N*DATA_WIDTH-1:0]   attn,
   input  logic [N*N*DATA_WIDTH-1:0]   value,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N*N*DATA_WIDTH-1:0]   out
);
   localparam int ACC_W = 36;
   localparam int PW    = 2*DATA_WIDTH+1;
   localparam int BUS_W = N*N*DATA_WIDTH;
   localparam int CW    = (N > 1) ? $clog2(N) : 1;
   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (FRAC_BITS-1);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**(DATA_WIDTH-1)-1);
   localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(2**(DATA_WIDTH-1));
   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
   state_t state;
   logic [CW-1:0] row, k;
   logic [BUS_W-1:0] attn_q, value_q;
   logic [DATA_WIDTH-1:0] a_cur;
   logic [DATA_WIDTH-1:0] v_el [N];
   logic [DATA_WIDTH-1:0] sat [N];
   logic signed [PW-1:0] prod [N];
   logic signed [ACC_W-1:0] acc [N];
   logic signed [ACC_W-1:0] acc_nxt [N];
   logic signed [ACC_W-1:0] sh [N];
   assign in_ready = (state == IDLE) && rst_n;
   // N parallel MACs on A[row][k]*V[k][j], plus the rounded/saturated row result
   always_comb begin
      a_cur = attn_q[DATA_WIDTH*(N*int'(row)+int'(k)) +: DATA_WIDTH];
      for (int j = 0; j < N; j++) begin
         v_el[j]    = value_q[DATA_WIDTH*(N*int'(k)+j) +: DATA_WIDTH];
         prod[j]    = $signed({{(PW-DATA_WIDTH){1'b0}}, a_cur}) * $signed({{(PW-DATA_WIDTH){v_el[j][DATA_WIDTH-1]}}, v_el[j]});
         acc_nxt[j] = acc[j] + {{(ACC_W-PW){prod[j][PW-1]}}, prod[j]};
         sh[j]      = (acc_nxt[j] + RND) >>> FRAC_BITS;
         sat[j]     = (sh[j] > MAXV) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                      (sh[j] < MINV) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : sh[j][DATA_WIDTH-1:0];
      end
   end
   // control FSM, operand capture, accumulators and registered output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row       <= '0;
         k         <= '0;
         attn_q    <= '0;
         value_q   <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         for (int j = 0; j < N; j++) acc[j] <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               attn_q  <= attn;
               value_q <= value;
               row     <= '0;
               k       <= '0;
               state   <= COMPUTE;
               for (int j = 0; j < N; j++) acc[j] <= '0;
            end
            COMPUTE: if (k == CW'(N-1)) begin
               for (int j = 0; j < N; j++) begin
                  out[DATA_WIDTH*(N*int'(row)+j) +: DATA_WIDTH] <= sat[j];
                  acc[j] <= '0;
               end
               k   <= '0;
               row <= row + 1'b1;
               if (row == CW'(N-1)) begin
                  row       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end else begin
               for (int j = 0; j < N; j++) acc[j] <= acc_nxt[j];
               k <= k + 1'b1;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_attn_value_matmul.sv
// tb_attn_value_matmul: directed vector table plus backpressure and reset-abort sequences
module tb_attn_value_matmul;
   localparam int N  = 8;
   localparam int DW = 16;
   localparam int BW = N*N*DW;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic in_ready, out_valid;
   logic [BW-1:0] attn = '0;
   logic [BW-1:0] value = '0;
   logic [BW-1:0] out;
   int n_cmp = 0;
   int n_fail = 0;
   typedef struct {
      string name;
      logic [BW-1:0] a;
      logic [BW-1:0] v;
      logic [BW-1:0] e;
   } vec_t;
   vec_t vecs [6];
   logic [BW-1:0] id_a, id_v;

   attn_value_matmul #(.DATA_WIDTH(DW), .FRAC_BITS(8), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .attn(attn), .value(value), .out_valid(out_valid), .out_ready(out_ready), .out(out)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic check_bus(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      int bad;
      n_cmp++;
      bad = -1;
      for (int i = N*N-1; i >= 0; i--)
         if (act[DW*i +: DW] !== exp[DW*i +: DW]) bad = i;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: element (%0d,%0d) got %h want %h", nm, bad/N, bad%N, act[DW*bad +: DW], exp[DW*bad +: DW]);
      end
   endtask

   task automatic accept_and_wait(input string nm, input logic [BW-1:0] a, input logic [BW-1:0] v);
      int cnt;
      @(negedge clk);
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check({nm, " in_ready before accept"}, in_ready, 1);
      attn = a;
      value = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      attn = '1;
      value = '1;
      check({nm, " in_ready after accept"}, in_ready, 0);
      cnt = 0;
      while (!out_valid && cnt < 200) begin
         @(posedge clk);
         cnt++;
         #1;
      end
      check({nm, " latency"}, cnt, N*N);
   endtask

   task automatic handoff(input string nm);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({nm, " out_valid after handoff"}, out_valid, 0);
      check({nm, " in_ready after handoff"}, in_ready, 1);
   endtask

   function automatic logic [BW-1:0] all_el(input logic [DW-1:0] x);
      logic [BW-1:0] b;
      for (int i = 0; i < N*N; i++) b[DW*i +: DW] = x;
      return b;
   endfunction

   function automatic logic [BW-1:0] rand_bus();
      logic [BW-1:0] b;
      for (int i = 0; i < N*N; i++) b[DW*i +: DW] = DW'($urandom);
      return b;
   endfunction

   initial begin
      id_a = '0;
      for (int i = 0; i < N; i++) id_a[DW*(i*N+i) +: DW] = 16'h0100;
      vecs[0].name = "identity";
      vecs[0].a = id_a;
      vecs[0].v = rand_bus();
      vecs[0].e = vecs[0].v;
      vecs[1].name = "uniform";
      vecs[1].a = all_el(16'h0020);
      vecs[1].v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) vecs[1].v[DW*(r*N+c) +: DW] = DW'(r*256);
      vecs[1].e = all_el(16'h0380);
      vecs[2].name = "sat_pos";
      vecs[2].a = all_el(16'h0100);
      vecs[2].v = all_el(16'h7000);
      vecs[2].e = all_el(16'h7FFF);
      vecs[3].name = "sat_neg";
      vecs[3].a = all_el(16'h0100);
      vecs[3].v = all_el(16'h9000);
      vecs[3].e = all_el(16'h8000);
      vecs[4].name = "round_up";
      vecs[4].a = '0;
      vecs[4].a[DW-1:0] = 16'h0001;
      vecs[4].v = '0;
      vecs[4].v[DW-1:0] = 16'h0080;
      vecs[4].e = '0;
      vecs[4].e[DW-1:0] = 16'h0001;
      vecs[5].name = "round_down";
      vecs[5].a = vecs[4].a;
      vecs[5].v = '0;
      vecs[5].v[DW-1:0] = 16'h007F;
      vecs[5].e = '0;

      #2 rst_n = 1'b0;
      #1;
      check("reset in_ready", in_ready, 0);
      check("reset out_valid", out_valid, 0);
      check_bus("reset out", out, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("in_ready after release", in_ready, 1);

      for (int t = 0; t < 6; t++) begin
         accept_and_wait(vecs[t].name, vecs[t].a, vecs[t].v);
         check_bus({vecs[t].name, " out"}, out, vecs[t].e);
         handoff(vecs[t].name);
      end

      accept_and_wait("backpressure", vecs[1].a, vecs[1].v);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid = (c == 3);
         attn = '0;
         value = all_el(16'h0100);
         @(posedge clk);
         #1;
         check("backpressure out_valid", out_valid, 1);
         check("backpressure in_ready", in_ready, 0);
         check_bus("backpressure out", out, vecs[1].e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      handoff("backpressure");
      @(negedge clk);
      check("no stray accept", in_ready, 1);

      accept_and_wait("pre_reset", vecs[2].a, vecs[2].v);
      handoff("pre_reset");
      @(negedge clk);
      attn = id_a;
      value = rand_bus();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort out_valid", out_valid, 0);
      check("abort in_ready", in_ready, 0);
      check_bus("abort out", out, '0);
      @(negedge clk);
      rst_n = 1'b1;
      vecs[0].v = rand_bus();
      accept_and_wait("identity_after_reset", id_a, vecs[0].v);
      check_bus("identity_after_reset out", out, vecs[0].v);
      handoff("identity_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/attn_value_matmul.md
# attn_value_matmul

Sequential matrix multiplier that computes O = A·V for one attention head. A is the N×N probability matrix produced by the softmax stage and V is the N×N value matrix. The block sits directly downstream of the combinational softmax stage and captures its flat output bus together with a V bus. It computes one output row every N cycles using N parallel MACs, then presents the result on a flat bus with a valid/ready handshake.

## Interface
- DATA_WIDTH, 16: element width; all elements are Q8.8.
- FRAC_BITS, 8: fractional bits of every operand and of the result.
- N, 8: matrix dimension (rows = cols = N).
- clk  in  1: clock; all state changes on the rising edge.
- rst_n  in  1: reset. Asynchronous, active-low, single clock domain.
- in_valid  in  1: attn and value are valid.
- in_ready  out  1: block can accept an input; equals (state==IDLE) && rst_n.
- attn  in  N*N*DATA_WIDTH: A, unsigned Q8.8. Element (i,j) is at bits [16*(i*N+j+1)-1 : 16*(i*N+j)].
- value  in  N*N*DATA_WIDTH: V, signed two's-complement Q8.8, same packing as attn.
- out_valid  out  1: out holds a complete result.
- out_ready  in  1: consumer accepts out.
- out  out  N*N*DATA_WIDTH: O, signed Q8.8, same packing; registered.

## Operation
- FSM states: IDLE, COMPUTE, DONE. Reset state is IDLE.
- IDLE
  - in_ready = 1.
  - On in_valid: register both buses, clear the N accumulators, set row=0 and k=0, go to COMPUTE.
- COMPUTE
  - Each cycle, for all j in parallel: acc[j] += A[row][k] * V[k][j].
  - Each product is 16u×16s and is formed as a 33-bit signed value, Q16.16.
  - Accumulators are 36-bit signed. This width cannot overflow for N=8.
- End of a row (k==N-1)
  - out row `row`, column j = sat16((acc[j] + A[row][k]*V[k][j] + 2^(FRAC_BITS-1)) >>> FRAC_BITS). This is round-half-up followed by an arithmetic shift.
  - sat16 clamps the value to [0x8000, 0x7FFF].
  - Accumulators clear, k returns to 0, row increments.
- End of the last row (row==N-1, k==N-1): go to DONE.
- DONE
  - out_valid = 1. out and out_valid stay stable until out_ready is high.
  - On out_ready: go to IDLE.
- Input handling
  - in_valid is ignored in any state other than IDLE.
  - The captured input registers decouple the block from the upstream bus after the accept edge.
- No overlap: a new input is accepted only after the previous result has been handed off.
- Rows of out that have not been written yet hold their previous contents. out is meaningful only while out_valid is high.

## Timing
- Reset (rst_n low), asynchronously:
  - state=IDLE, row=0, k=0.
  - All accumulators = 0, out = 0, out_valid = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 once rst_n is high.
- Reset asserted mid-COMPUTE or in DONE aborts the operation. Nothing partial is ever flagged valid.
- Accept edge T (in_valid && in_ready):
  - in_ready is low from T.
  - COMPUTE runs on edges T+1 … T+N*N.
  - out_valid is high after edge T+N*N. For N=8 that is 64 cycles.
- Output handshake edge H (out_valid && out_ready):
  - out_valid is low after H, in_ready is high after H.
  - Earliest next accept is edge H+1.
  - Throughput: one matrix per N*N+2 cycles when out_ready is held high.
- out_ready high before out_valid has no effect.

## Test plan
- **Identity.** attn diagonal = 0x0100 and all other entries 0; value = random signed data → out == value bit-exact, with out_valid exactly 64 cycles after the accept edge.
- **Uniform attention.** attn all 0x0020 (1/8); value row k all k·0x0100 → every out element = 0x0380 (3.5).
- **Saturation.**
  - attn all 0x0100 and value all 0x7000 → every out element = 0x7FFF.
  - attn all 0x0100 and value all 0x9000 → every out element = 0x8000.
- **Rounding.**
  - attn[0][0]=0x0001, value[0][0]=0x0080, all else 0 → out[0][0]=0x0001.
  - The same with value[0][0]=0x007F → out[0][0]=0x0000.
- **Backpressure.** Hold out_ready low for 10 cycles after out_valid rises → out and out_valid stay stable and in_ready stays 0. An in_valid pulse with different data during this window is ignored. out_ready high → in_ready high on the next cycle.
- **Reset mid-compute.** Assert rst_n low 30 cycles after an accept → out_valid=0, out=0 immediately. After release, a fresh identity test passes with 64-cycle latency.
